// File: rtl/arm_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the NZCV flag bit positions used by the ALU and condition logic.
package arm_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // C and V are never produced by this unit.
  function automatic logic [3:0] pack_flags(input logic n, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: right-shift shift-add for multiply, or left-shift
// restoring compare-subtract for divide, over the {acc, q} register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  assign sum_s    = {1'b0, acc} + {1'b0, operand};
  assign rem_sh_s = {acc, q[WIDTH-1]};
  assign diff_s   = rem_sh_s - {1'b0, operand};

  // diff_s MSB acts as the borrow: set means the trial subtract is restored.
  always_comb begin
    acc_next = acc;
    q_next   = q;
    if (div_mode) begin
      if (!diff_s[WIDTH]) begin
        acc_next = diff_s[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_sh_s[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      {acc_next, q_next} = {sum_s, q[WIDTH-1:1]};
    end else begin
      {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/arm_muldiv_unit.sv
// Iterative MUL/UMULL/UDIV/SDIV unit beside the ALU: fixed WIDTH-cycle latency,
// busy while iterating, one-cycle done with registered results and NZCV flags.
module arm_muldiv_unit
  import arm_muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_r;
  state_e           state_s;
  op_e              op_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] a_r;
  logic             b_zero_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] result_lo_r;
  logic [WIDTH-1:0] result_hi_r;
  logic [3:0]       flags_r;

  logic             accept_s;
  logic             last_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             div_mode_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] res_lo_s;
  logic [WIDTH-1:0] res_hi_s;
  logic             res_dbz_s;
  logic             n_s;
  logic             z_s;

  // Signed divide works on magnitudes; the most-negative value maps onto
  // itself, which as an unsigned magnitude is exactly right.
  assign a_neg_s    = (op == OP_SDIV) && a[WIDTH-1];
  assign b_neg_s    = (op == OP_SDIV) && b[WIDTH-1];
  assign a_mag_s    = a_neg_s ? -a : a;
  assign b_mag_s    = b_neg_s ? -b : b;
  assign div_mode_s = op_r[1] & DIV_EN;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode(div_mode_s),
    .acc     (acc_r),
    .q       (q_r),
    .operand (opnd_r),
    .acc_next(acc_next_s),
    .q_next  (q_next_s)
  );

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == CW'(WIDTH - 1)) begin
          state_s = DONE;
          last_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Final result selection from the last step output, with sign post-correction.
  always_comb begin
    res_lo_s  = {WIDTH{1'b0}};
    res_hi_s  = {WIDTH{1'b0}};
    res_dbz_s = 1'b0;
    case (op_r)
      OP_MUL: begin
        res_lo_s = q_next_s;
      end
      OP_UMULL: begin
        res_lo_s = q_next_s;
        res_hi_s = acc_next_s;
      end
      OP_UDIV, OP_SDIV: begin
        if (DIV_EN == 1'b0) begin
          res_lo_s = {WIDTH{1'b0}};
        end else if (b_zero_r) begin
          res_hi_s  = a_r;
          res_dbz_s = 1'b1;
        end else begin
          res_lo_s = neg_q_r ? -q_next_s : q_next_s;
          res_hi_s = neg_r_r ? -acc_next_s : acc_next_s;
        end
      end
      default: res_lo_s = {WIDTH{1'b0}};
    endcase
    if (op_r == OP_UMULL) begin
      n_s = res_hi_s[WIDTH-1];
      z_s = ~|{res_hi_s, res_lo_s};
    end else begin
      n_s = res_lo_s[WIDTH-1];
      z_s = ~|res_lo_s;
    end
  end

  // State, status and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      op_r     <= OP_MUL;
      acc_r    <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_zero_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      count_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        op_r     <= op_e'(op);
        acc_r    <= {WIDTH{1'b0}};
        q_r      <= op[1] ? a_mag_s : b;
        opnd_r   <= op[1] ? b_mag_s : a;
        a_r      <= a;
        b_zero_r <= (b == {WIDTH{1'b0}});
        neg_q_r  <= a_neg_s ^ b_neg_s;
        neg_r_r  <= a_neg_s;
        count_r  <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        acc_r   <= acc_next_s;
        q_r     <= q_next_s;
        count_r <= count_r + CW'(1'b1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Result registers load only on DONE entry and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_lo_r <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      dbz_r       <= 1'b0;
    end else if (last_s) begin
      result_lo_r <= res_lo_s;
      result_hi_r <= res_hi_s;
      flags_r     <= pack_flags(n_s, z_s);
      dbz_r       <= res_dbz_s;
    end else begin
      dbz_r <= dbz_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result_lo = result_lo_r;
  assign result_hi = result_hi_r;
  assign flags     = flags_r;
  assign dbz       = dbz_r;

endmodule

// File: tb/tb_arm_muldiv_unit.sv
// Scoreboard bench for arm_muldiv_unit (WIDTH=32): a reference model queues
// expected results at each accepted start; a monitor checks timing and results.
module tb_arm_muldiv_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic         dbz;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  int   mst = 0;  // 0 idle, 1 run, 2 done
  int   mcnt = 0;

  arm_muldiv_unit #(.WIDTH(W), .DIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flags(flags), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    logic n, z;
    e.lo = 32'h0; e.hi = 32'h0; e.dbz = 1'b0;
    p = {32'h0, x} * {32'h0, y};
    case (o)
      2'b00: e.lo = p[31:0];
      2'b01: begin e.lo = p[31:0]; e.hi = p[63:32]; end
      2'b10: begin
        if (y == 32'h0) begin e.hi = x; e.dbz = 1'b1; end
        else begin e.lo = x / y; e.hi = x % y; end
      end
      default: begin
        if (y == 32'h0) begin e.hi = x; e.dbz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin e.lo = x; e.hi = 32'h0; end
        else begin e.lo = $signed(x) / $signed(y); e.hi = $signed(x) % $signed(y); end
      end
    endcase
    n = (o == 2'b01) ? e.hi[31] : e.lo[31];
    z = (o == 2'b01) ? ({e.hi, e.lo} == 64'h0) : (e.lo == 32'h0);
    e.fl = {n, z, 2'b00};
    return e;
  endfunction

  // Monitor: timing model and scoreboard comparison, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      mst = 0;
      sb.delete();
    end else begin
      case (mst)
        0: if (start) begin sb.push_back(model(op, a, b)); mst = 1; mcnt = 0; end
        1: begin mcnt++; if (mcnt == W) mst = 2; end
        default: begin
          if (start) begin sb.push_back(model(op, a, b)); mst = 1; mcnt = 0; end
          else mst = 0;
        end
      endcase
    end
    check("busy", {63'h0, busy}, {63'h0, (mst == 1)});
    check("done", {63'h0, done}, {63'h0, (mst == 2)});
    if (mst == 2) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result_lo", {32'h0, result_lo}, {32'h0, e.lo});
        check("result_hi", {32'h0, result_hi}, {32'h0, e.hi});
        check("flags", {60'h0, flags}, {60'h0, e.fl});
        check("dbz", {63'h0, dbz}, {63'h0, e.dbz});
      end
    end
  end

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check(tag, {63'h0, seen}, 64'd1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3));
    wait_done("done_timeout");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_lo", {32'h0, result_lo}, 64'h0);
    check("rst_hi", {32'h0, result_hi}, 64'h0);
    check("rst_flags", {60'h0, flags}, 64'h0);
    check("rst_busy_dbz", {62'h0, busy, dbz}, 64'h0);

    issue(2'b00, 32'd7, 32'd6);
    check("mul_7x6", {result_hi, result_lo}, 64'd42);
    check("mul_flags", {60'h0, flags}, 64'h0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("umull_max", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    check("umull_flags", {60'h0, flags}, 64'h8);
    issue(2'b10, 32'd100, 32'd7);
    check("udiv_100_7", {result_hi, result_lo}, {32'd2, 32'd14});
    issue(2'b11, 32'hFFFF_FF9C, 32'd7);
    check("sdiv_m100_7", {result_hi, result_lo}, 64'hFFFF_FFFE_FFFF_FFF2);
    check("sdiv_flags", {60'h0, flags}, 64'h8);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check("sdiv_ovf", {result_hi, result_lo}, 64'h0000_0000_8000_0000);
    issue(2'b10, 32'd55, 32'd0);
    check("udiv_dbz", {result_hi, result_lo}, {32'd55, 32'd0});
    check("udiv_dbz_flag", {59'h0, dbz, flags}, 64'h14);
    issue(2'b11, 32'd100, 32'hFFFF_FFF9);
    issue(2'b11, 32'hFFFF_FFF9, 32'd0);
    for (int i = 0; i < 6; i++) issue(2'($urandom_range(3)), $urandom, $urandom);

    // Start held high across ops: second op accepted in the DONE cycle.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(negedge clk);
    a = 32'd5; b = 32'd5;
    wait_done("b2b_first");
    check("b2b_9", {32'h0, result_lo}, 64'd9);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second");
    check("b2b_25", {32'h0, result_lo}, 64'd25);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_res", {result_hi, result_lo}, 64'h0);
    check("midrst_flags", {60'h0, flags}, 64'h0);
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd2, 32'd2);
    check("mul_2x2", {32'h0, result_lo}, 64'd4);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
